// File: rtl/cpu_pkg.sv
// Shared encodings and decoded-control types for the single-cycle MIPS-32 datapath.
package cpu_pkg;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnNor = 6'b100111;
   localparam logic [5:0] FnSlt = 6'b101010;
   localparam logic [5:0] FnSll = 6'b000000;
   localparam logic [5:0] FnSrl = 6'b000010;

   typedef enum logic [3:0] {
      AluAdd, AluSub, AluAnd, AluOr, AluNor, AluSlt, AluSll, AluSrl, AluLui
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    dst_is_rd;
      logic    alu_src_imm;
      logic    imm_zext;
      logic    mem_read;
      logic    mem_write;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CtrlNop = '{
      reg_write:   1'b0,
      dst_is_rd:   1'b0,
      alu_src_imm: 1'b0,
      imm_zext:    1'b0,
      mem_read:    1'b0,
      mem_write:   1'b0,
      alu_op:      AluAdd
   };

endpackage

// File: rtl/cpu_regfile.sv
// 32x32 general-purpose register file: two operand read ports, a debug read port,
// one synchronous write port and synchronous reset. Register 0 always reads as zero.
module cpu_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr_a,
   output logic [31:0] rdata_a,
   input  logic [4:0]  raddr_b,
   output logic [31:0] rdata_b,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   logic [31:0] regs [32];

   // Reset wins over a same-cycle writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we && (waddr != 5'd0)) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata_a  = (raddr_a  == 5'd0) ? '0 : regs[raddr_a];
   assign rdata_b  = (raddr_b  == 5'd0) ? '0 : regs[raddr_b];
   assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/cpu.sv
// Single-cycle MIPS-32 integer datapath: decode, ALU and data memory, one instruction
// retired per rising clock edge. Undefined encodings retire as NOPs.
module cpu
   import cpu_pkg::*;
#(
   parameter int unsigned DMEM_WORDS = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Inst,
   input  logic [4:0]  dbg_addr,
   output logic [31:0] dbg_data
);

   localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm;
   ctrl_t       ctrl;
   logic [31:0] rs_data, rt_data, src_b, alu_y, wb_data;
   logic [4:0]  waddr;
   logic [DmemAw-1:0] dmem_idx;
   logic [31:0] dmem [DMEM_WORDS];

   assign op    = Inst[31:26];
   assign rs    = Inst[25:21];
   assign rt    = Inst[20:16];
   assign rd    = Inst[15:11];
   assign shamt = Inst[10:6];
   assign funct = Inst[5:0];
   assign imm   = Inst[15:0];

   always_comb begin
      ctrl = CtrlNop;
      case (op)
         OpRtype: begin
            ctrl.reg_write = 1'b1;
            ctrl.dst_is_rd = 1'b1;
            case (funct)
               FnAdd:   ctrl.alu_op = AluAdd;
               FnSub:   ctrl.alu_op = AluSub;
               FnAnd:   ctrl.alu_op = AluAnd;
               FnOr:    ctrl.alu_op = AluOr;
               FnNor:   ctrl.alu_op = AluNor;
               FnSlt:   ctrl.alu_op = AluSlt;
               FnSll:   ctrl.alu_op = AluSll;
               FnSrl:   ctrl.alu_op = AluSrl;
               default: ctrl.reg_write = 1'b0;
            endcase
         end
         OpAddi: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
         end
         OpAndi: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.imm_zext    = 1'b1;
            ctrl.alu_op      = AluAnd;
         end
         OpOri: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.imm_zext    = 1'b1;
            ctrl.alu_op      = AluOr;
         end
         OpSlti: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.alu_op      = AluSlt;
         end
         OpLui: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = AluLui;
         end
         OpLw: begin
            ctrl.reg_write   = 1'b1;
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_read    = 1'b1;
         end
         OpSw: begin
            ctrl.alu_src_imm = 1'b1;
            ctrl.mem_write   = 1'b1;
         end
         default: ;
      endcase
   end

   assign src_b = !ctrl.alu_src_imm ? rt_data :
                  ctrl.imm_zext     ? {16'h0000, imm} : {{16{imm[15]}}, imm};

   always_comb begin
      alu_y = '0;
      case (ctrl.alu_op)
         AluAdd:  alu_y = rs_data + src_b;
         AluSub:  alu_y = rs_data - src_b;
         AluAnd:  alu_y = rs_data & src_b;
         AluOr:   alu_y = rs_data | src_b;
         AluNor:  alu_y = ~(rs_data | src_b);
         AluSlt:  alu_y = {31'b0, $signed(rs_data) < $signed(src_b)};
         AluSll:  alu_y = src_b << shamt;
         AluSrl:  alu_y = src_b >> shamt;
         AluLui:  alu_y = {imm, 16'h0000};
         default: alu_y = '0;
      endcase
   end

   // Byte offset and high address bits are dropped, so accesses wrap the memory.
   assign dmem_idx = alu_y[DmemAw+1:2];

   logic unused_addr;
   assign unused_addr = ^{alu_y[31:DmemAw+2], alu_y[1:0]};

   always_ff @(posedge clk) begin
      if (!rst && ctrl.mem_write) begin
         dmem[dmem_idx] <= rt_data;
      end
   end

   assign wb_data = ctrl.mem_read ? dmem[dmem_idx] : alu_y;
   assign waddr   = ctrl.dst_is_rd ? rd : rt;

   cpu_regfile u_regfile (
      .clk      (clk),
      .rst      (rst),
      .we       (ctrl.reg_write),
      .waddr    (waddr),
      .wdata    (wb_data),
      .raddr_a  (rs),
      .rdata_a  (rs_data),
      .raddr_b  (rt),
      .rdata_b  (rt_data),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

endmodule

// File: tb/tb_cpu.sv
// Directed-instruction bench for cpu: expected register values are queued by the
// stimulus and compared through the debug port by an independent monitor.
`timescale 1ns/1ps
module tb_cpu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] Inst;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] value;
      string       name;
   } exp_t;

   exp_t sb[$];

   cpu #(.DMEM_WORDS(256)) dut (
      .clk      (clk),
      .rst      (rst),
      .Inst     (Inst),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh);
      return {6'b000000, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic step(input logic [31:0] i, input logic r);
      @(negedge clk);
      Inst = i;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   task automatic exec(input logic [31:0] i);
      step(i, 1'b0);
   endtask

   task automatic expect_reg(input logic [4:0] a, input logic [31:0] v, input string n);
      exp_t e;
      e.addr  = a;
      e.value = v;
      e.name  = n;
      sb.push_back(e);
   endtask

   // Monitor: drains queued expectations at each falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            dbg_addr = e.addr;
            #0.2;
            checks++;
            if (dbg_data !== e.value) begin
               errors++;
               $display("FAIL %s: $%0d got %h expected %h", e.name, e.addr, dbg_data, e.value);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [31:0] m1, m2;
      logic [4:0]  d;
      dbg_addr = 5'd0;
      Inst     = 32'h0;
      rst      = 1'b1;
      step(32'h0, 1'b1);
      step(32'h0, 1'b1);
      expect_reg(5'd1, 32'h0, "reset_r1");
      expect_reg(5'd31, 32'h0, "reset_r31");

      // Reset clears registers and suppresses the same-cycle write.
      exec(itype(6'b001000, 5'd0, 5'd5, 16'd7));
      expect_reg(5'd5, 32'd7, "addi_r5");
      step(itype(6'b001000, 5'd0, 5'd5, 16'd9), 1'b1);
      expect_reg(5'd5, 32'd0, "rst_pulse_r5");
      exec(itype(6'b001000, 5'd0, 5'd0, 16'd5));
      expect_reg(5'd0, 32'd0, "r0_hardwired");

      // Doubling sequence.
      exec(itype(6'b001000, 5'd0, 5'd1, 16'd1));
      exec(itype(6'b001000, 5'd0, 5'd2, 16'd1));
      m1 = 32'd1;
      m2 = 32'd1;
      for (int k = 0; k < 10; k++) begin
         d = (k % 2 == 0) ? 5'd1 : 5'd2;
         exec(rtype(6'b100000, 5'd1, 5'd1, d, 5'd0));
         if (d == 5'd1) m1 = m1 * 2;
         else           m2 = m1 * 2;
      end
      expect_reg(5'd1, m1, "double_r1");
      expect_reg(5'd2, m2, "double_r2");
      expect_reg(5'd1, 32'd32, "double_r1_const");
      expect_reg(5'd2, 32'd64, "double_r2_const");

      // ALU basics.
      exec(itype(6'b001000, 5'd0, 5'd3, 16'hFFFF));
      expect_reg(5'd3, 32'hFFFF_FFFF, "addi_neg");
      exec(rtype(6'b100000, 5'd3, 5'd3, 5'd4, 5'd0));
      expect_reg(5'd4, 32'hFFFF_FFFE, "add_wrap");
      exec(rtype(6'b101010, 5'd3, 5'd0, 5'd5, 5'd0));
      expect_reg(5'd5, 32'd1, "slt_signed");
      exec(rtype(6'b101011, 5'd3, 5'd0, 5'd4, 5'd0));
      expect_reg(5'd4, 32'hFFFF_FFFE, "sltu_nop");

      // Immediates.
      exec(itype(6'b001111, 5'd0, 5'd6, 16'h1234));
      exec(itype(6'b001101, 5'd6, 5'd6, 16'h5678));
      expect_reg(5'd6, 32'h1234_5678, "lui_ori");
      exec(itype(6'b001100, 5'd6, 5'd7, 16'h00FF));
      expect_reg(5'd7, 32'h0000_0078, "andi");
      exec(itype(6'b001101, 5'd0, 5'd18, 16'h8000));
      expect_reg(5'd18, 32'h0000_8000, "ori_zext");
      exec(itype(6'b001000, 5'd0, 5'd19, 16'h8000));
      expect_reg(5'd19, 32'hFFFF_8000, "addi_sext");
      exec(itype(6'b001010, 5'd3, 5'd15, 16'h0000));
      expect_reg(5'd15, 32'd1, "slti_true");
      exec(itype(6'b001010, 5'd6, 5'd16, 16'hFFFF));
      expect_reg(5'd16, 32'd0, "slti_false");

      // Remaining R-type ops.
      exec(rtype(6'b100010, 5'd6, 5'd7, 5'd10, 5'd0));
      expect_reg(5'd10, 32'h1234_5600, "sub");
      exec(rtype(6'b100100, 5'd6, 5'd7, 5'd11, 5'd0));
      expect_reg(5'd11, 32'h0000_0078, "and");
      exec(rtype(6'b100111, 5'd6, 5'd0, 5'd12, 5'd0));
      expect_reg(5'd12, 32'hEDCB_A987, "nor");
      exec(rtype(6'b000000, 5'd0, 5'd6, 5'd13, 5'd4));
      expect_reg(5'd13, 32'h2345_6780, "sll");
      exec(rtype(6'b000010, 5'd0, 5'd6, 5'd14, 5'd8));
      expect_reg(5'd14, 32'h0012_3456, "srl");
      exec(rtype(6'b100101, 5'd7, 5'd5, 5'd17, 5'd0));
      expect_reg(5'd17, 32'h0000_0079, "or");

      // Memory, including ignored byte offset and address wrap.
      exec(itype(6'b101011, 5'd0, 5'd6, 16'd8));
      exec(itype(6'b100011, 5'd0, 5'd8, 16'd8));
      expect_reg(5'd8, 32'h1234_5678, "lw");
      exec(itype(6'b100011, 5'd0, 5'd9, 16'd1032));
      expect_reg(5'd9, 32'h1234_5678, "lw_wrap");
      exec(itype(6'b101011, 5'd0, 5'd7, 16'd13));
      exec(itype(6'b100011, 5'd0, 5'd20, 16'd12));
      expect_reg(5'd20, 32'h0000_0078, "sw_unaligned");
      exec(itype(6'b100011, 5'd0, 5'd21, 16'd8));
      expect_reg(5'd21, 32'h1234_5678, "sw_no_clobber");

      // Overflow and undefined encodings.
      exec(itype(6'b001000, 5'd0, 5'd1, 16'h7FFF));
      expect_reg(5'd1, 32'h0000_7FFF, "addi_7fff");
      exec(itype(6'b001111, 5'd0, 5'd1, 16'h7FFF));
      exec(itype(6'b001101, 5'd1, 5'd1, 16'hFFFF));
      expect_reg(5'd1, 32'h7FFF_FFFF, "max_pos");
      exec(rtype(6'b100000, 5'd1, 5'd1, 5'd2, 5'd0));
      expect_reg(5'd2, 32'hFFFF_FFFE, "add_overflow");
      exec({6'b111111, 5'd1, 5'd2, 16'hFFFF});
      expect_reg(5'd2, 32'hFFFF_FFFE, "undef_op_r2");
      expect_reg(5'd1, 32'h7FFF_FFFF, "undef_op_r1");
      exec(rtype(6'b111111, 5'd1, 5'd1, 5'd3, 5'd0));
      expect_reg(5'd3, 32'hFFFF_FFFF, "undef_funct");
      exec(32'h0);
      expect_reg(5'd6, 32'h1234_5678, "zero_inst");

      repeat (3) @(posedge clk);
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
